fir_uart_stream_ctrl: RTL and testbench

//  Parametrised successor to the FIR/UART wrapper controller. Sequences one FIR transaction:

---
 rtl/fir_uart_stream_ctrl.sv | 126 ++++++++++++
 tb/tb_fir_uart_stream_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_uart_stream_ctrl.sv
// fir_uart_stream_ctrl: sequences UART byte collection, one FIR run and UART result transmission
module fir_uart_stream_ctrl #(
   parameter int IN_BYTES    = 2,
   parameter int OUT_BYTES   = 2,
   parameter int TIMEOUT_CYC = 0,
   parameter bit STREAM      = 1'b0,
   localparam int MAX_BYTES  = IN_BYTES > OUT_BYTES ? IN_BYTES : OUT_BYTES,
   localparam int IDX_W      = $clog2(MAX_BYTES) > 1 ? $clog2(MAX_BYTES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_data_ready_i,
   input  logic             fir_out_valid_i,
   input  logic             tx_busy_i,
   output logic             rx_ld_o,
   output logic [IDX_W-1:0] rx_sel_o,
   output logic             fir_in_valid_o,
   output logic             res_ld_o,
   output logic             tx_start_o,
   output logic [IDX_W-1:0] tx_sel_o,
   output logic             done_o,
   output logic             timeout_err_o,
   output logic             rx_overrun_o
);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1) > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [IDX_W-1:0] RX_LAST  = IDX_W'(IN_BYTES - 1);
   localparam logic [IDX_W-1:0] TX_LAST  = IDX_W'(OUT_BYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [3:0] {
      RECV, START_FIR, WAIT_FIR, CAPTURE, TX_SEND, TX_HOLD, TX_WAIT, DONE, IDLE
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] rx_cnt_q;
   logic [IDX_W-1:0] tx_cnt_q;
   logic [TMR_W-1:0] timer_q;
   logic             fir_in_valid_q;
   logic             res_ld_q;
   logic             done_q;
   logic             in_recv;
   logic             tmo;

   // A partial sample expires only while bytes are pending; a byte arriving on the last cycle wins.
   assign in_recv = state_q == RECV;
   assign tmo     = TIMEOUT_CYC > 0 && in_recv && rx_cnt_q != '0 && timer_q == TMR_LAST && !rx_data_ready_i;

   // Mealy strobes are gated by rst_n so they vanish the moment reset is asserted.
   assign rx_ld_o        = rst_n && in_recv && rx_data_ready_i;
   assign rx_overrun_o   = rst_n && !in_recv && rx_data_ready_i;
   assign timeout_err_o  = rst_n && tmo;
   assign tx_start_o     = rst_n && state_q == TX_SEND && !tx_busy_i;
   assign rx_sel_o       = rx_cnt_q;
   assign tx_sel_o       = tx_cnt_q;
   assign fir_in_valid_o = fir_in_valid_q;
   assign res_ld_o       = res_ld_q;
   assign done_o         = done_q;

   // Transaction sequencer: state, byte counters, inter-byte timer and registered one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RECV;
         rx_cnt_q       <= '0;
         tx_cnt_q       <= '0;
         timer_q        <= '0;
         fir_in_valid_q <= 1'b0;
         res_ld_q       <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         fir_in_valid_q <= 1'b0;
         res_ld_q       <= 1'b0;
         done_q         <= 1'b0;
         case (state_q)
            RECV: begin
               if (rx_data_ready_i) begin
                  timer_q <= '0;
                  if (rx_cnt_q == RX_LAST) begin
                     rx_cnt_q       <= '0;
                     state_q        <= START_FIR;
                     fir_in_valid_q <= 1'b1;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + IDX_W'(1);
                  end
               end else if (tmo) begin
                  rx_cnt_q <= '0;
                  timer_q  <= '0;
               end else if (TIMEOUT_CYC > 0 && rx_cnt_q != '0) begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            START_FIR: state_q <= WAIT_FIR;
            WAIT_FIR: begin
               if (fir_out_valid_i) begin
                  state_q  <= CAPTURE;
                  res_ld_q <= 1'b1;
               end
            end
            CAPTURE: begin
               tx_cnt_q <= '0;
               state_q  <= TX_SEND;
            end
            TX_SEND: state_q <= tx_busy_i ? TX_SEND : TX_HOLD;
            TX_HOLD: state_q <= TX_WAIT;
            TX_WAIT: begin
               if (!tx_busy_i) begin
                  if (tx_cnt_q == TX_LAST) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     tx_cnt_q <= tx_cnt_q + IDX_W'(1);
                     state_q  <= TX_SEND;
                  end
               end
            end
            DONE: state_q <= STREAM ? RECV : IDLE;
            IDLE: state_q <= RECV;
            default: begin
               state_q  <= RECV;
               rx_cnt_q <= '0;
               tx_cnt_q <= '0;
               timer_q  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_uart_stream_ctrl.sv
// tb_fir_uart_stream_ctrl: scoreboard bench for the FIR/UART transaction sequencer
module tb_fir_uart_stream_ctrl;
   localparam logic [3:0] K_RX = 4'd1, K_FIV = 4'd2, K_RES = 4'd3, K_TX = 4'd4;
   localparam logic [3:0] K_DONE = 4'd5, K_TMO = 4'd6, K_OVR = 4'd7;
   localparam int TX_LEN = 20;

   typedef struct {
      logic [7:0] code;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b0;
   logic fov = 1'b0;
   logic hold_busy = 1'b0;
   logic sel = 1'b0;
   logic start_seen = 1'b0;
   logic tx_busy;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   k, c;
   ev_t  exp_q[$];

   // output bundle: {rx_ld, rx_sel, fir_in_valid, res_ld, tx_start, tx_sel, done, timeout_err, rx_overrun}
   logic [8:0] v0, v1, o;
   assign o = sel ? v1 : v0;

   fir_uart_stream_ctrl #(.IN_BYTES(2), .OUT_BYTES(2), .TIMEOUT_CYC(50), .STREAM(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .rx_data_ready_i(rx & ~sel), .fir_out_valid_i(fov & ~sel), .tx_busy_i(tx_busy & ~sel),
      .rx_ld_o(v0[8]), .rx_sel_o(v0[7]), .fir_in_valid_o(v0[6]), .res_ld_o(v0[5]),
      .tx_start_o(v0[4]), .tx_sel_o(v0[3]), .done_o(v0[2]), .timeout_err_o(v0[1]), .rx_overrun_o(v0[0])
   );

   fir_uart_stream_ctrl #(.IN_BYTES(2), .OUT_BYTES(2), .TIMEOUT_CYC(0), .STREAM(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .rx_data_ready_i(rx & sel), .fir_out_valid_i(fov & sel), .tx_busy_i(tx_busy & sel),
      .rx_ld_o(v1[8]), .rx_sel_o(v1[7]), .fir_in_valid_o(v1[6]), .res_ld_o(v1[5]),
      .tx_start_o(v1[4]), .tx_sel_o(v1[3]), .done_o(v1[2]), .timeout_err_o(v1[1]), .rx_overrun_o(v1[0])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: busy for TX_LEN cycles starting the cycle after tx_start
   always @(negedge clk) start_seen <= o[4];
   always @(posedge clk or negedge rst_n)
      if (!rst_n) busy_cnt <= 0;
      else if (start_seen) busy_cnt <= TX_LEN;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   assign tx_busy = busy_cnt > 0 || hold_busy;

   task automatic expect_ev(input logic [3:0] kind, input logic s, input int at);
      ev_t e;
      int  i;
      e.code = {kind, 3'b0, s};
      e.cyc  = at;
      i = exp_q.size();
      while (i > 0 && exp_q[i-1].cyc > at) i--;
      exp_q.insert(i, e);
   endtask

   task automatic check(input logic [7:0] code, input string tag);
      ev_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
         e.code = 8'h00;
         e.cyc  = -1;
      end
      vectors++;
      assert ({code, cyc} === {e.code, e.cyc}) else begin
         miscompares++;
         $error("FAIL %s: got code %h at cycle %0d, expected code %h at cycle %0d", tag, code, cyc, e.code, e.cyc);
      end
   endtask

   task automatic cmp(input string tag, input logic [8:0] got, input logic [8:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: got %b, expected %b", tag, got, want);
      end
   endtask

   task automatic drain(input string tag);
      vectors++;
      assert (exp_q.size() === 0) else begin
         miscompares++;
         $error("FAIL %s: %0d expected events never produced, expected 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   // every strobe the selected DUT raises must match the next scheduled expectation
   always @(negedge clk) begin
      if (o[8]) check({K_RX, 3'b0, o[7]}, "rx_ld");
      if (o[6]) check({K_FIV, 4'h0}, "fir_in_valid");
      if (o[5]) check({K_RES, 4'h0}, "res_ld");
      if (o[4]) check({K_TX, 3'b0, o[3]}, "tx_start");
      if (o[2]) check({K_DONE, 4'h0}, "done");
      if (o[1]) check({K_TMO, 4'h0}, "timeout_err");
      if (o[0]) check({K_OVR, 4'h0}, "rx_overrun");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_byte(input logic [3:0] kind, input logic s);
      rx = 1'b1;
      expect_ev(kind, s, cyc);
      step();
      rx = 1'b0;
   endtask

   // k = cycle of the last sample byte; called at cycle k+1
   task automatic finish_xact(input int lk, input bit ovr, input int hold, input int abort, input bit nxt);
      int t0, d, stop;
      t0 = hold > 0 ? lk + hold + 1 : lk + 8;
      d = t0 + 44;
      stop = abort > 0 ? lk + abort : d + 2;
      expect_ev(K_FIV, 1'b0, lk + 1);
      expect_ev(K_RES, 1'b0, lk + 7);
      expect_ev(K_TX, 1'b0, t0);
      if (t0 + 22 < stop) expect_ev(K_TX, 1'b1, t0 + 22);
      if (d < stop) expect_ev(K_DONE, 1'b0, d);
      while (cyc < stop) begin
         fov = cyc == lk + 6;
         hold_busy = hold > 0 && cyc <= lk + hold;
         rx = (ovr && (cyc == lk + 3 || cyc == lk + 15 || cyc == d + 1)) || (nxt && cyc == d + 1);
         if (rx) expect_ev(nxt ? K_RX : K_OVR, 1'b0, cyc);
         step();
      end
      fov = 1'b0;
      hold_busy = 1'b0;
      rx = 1'b0;
   endtask

   initial begin
      rx = 1'b1;
      step();
      step();
      cmp("reset_outputs", o, 9'b0);
      rx = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      // T1: basic transaction, bytes 10 cycles apart
      rx_byte(K_RX, 1'b0);
      repeat (9) step();
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 0, 1'b0);
      drain("T1_basic");
      // T2: single byte then silence times out after 50 cycles
      c = cyc;
      rx_byte(K_RX, 1'b0);
      expect_ev(K_TMO, 1'b0, c + 50);
      while (cyc < c + 52) step();
      rx_byte(K_RX, 1'b0);
      repeat (2) step();
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 0, 1'b0);
      drain("T2_timeout");
      // T3: second byte on the final timeout cycle wins
      c = cyc;
      rx_byte(K_RX, 1'b0);
      while (cyc < c + 50) step();
      rx_byte(K_RX, 1'b1);
      finish_xact(c + 50, 1'b0, 0, 0, 1'b0);
      drain("T3_edge_byte");
      // T4: overruns in WAIT_FIR, TX_WAIT and IDLE
      rx_byte(K_RX, 1'b0);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b1, 0, 0, 1'b0);
      drain("T4_overrun");
      rx_byte(K_RX, 1'b0);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 0, 1'b0);
      drain("T4_clean_after");
      // T5: streaming instance, tx busy held 30 cycles, next byte right after done
      sel = 1'b1;
      step();
      rx_byte(K_RX, 1'b0);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 30, 0, 1'b1);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 0, 1'b0);
      drain("T5_stream");
      sel = 1'b0;
      step();
      // T6: reset during TX_WAIT of the second byte
      rx_byte(K_RX, 1'b0);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 40, 1'b0);
      cmp("T6_tx_sel_before_reset", {8'b0, o[3]}, 9'd1);
      rst_n = 1'b0;
      rx = 1'b1;
      #1;
      cmp("T6_async_reset_outputs", o, 9'b0);
      step();
      step();
      rx = 1'b0;
      rst_n = 1'b1;
      drain("T6_abort");
      step();
      rx_byte(K_RX, 1'b0);
      k = cyc;
      rx_byte(K_RX, 1'b1);
      finish_xact(k, 1'b0, 0, 0, 1'b0);
      drain("T6_recovery");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
